// File: rtl/memory_controller_pkg.sv
// Shared constants, FSM state encoding and address helper for the BRAM memory controller.
package memory_controller_pkg;

    localparam int unsigned MAX_ROW = 360;
    localparam int unsigned MAX_COL = 540;
    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LEN_W   = 20;
    localparam int unsigned POS_W   = 10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MD1_READ   = 3'd1,
        MD1_DONE   = 3'd2,
        FETCH      = 3'd3,
        FETCH_DONE = 3'd4
    } mc_state_e;

    // Advance a frame address, wrapping to zero after the last pixel.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [ADDR_W-1:0] last);
        if (addr == last) begin
            next_addr = {ADDR_W{1'b0}};
        end else begin
            next_addr = addr + 18'd1;
        end
    endfunction

endpackage

// File: rtl/memory_controller_img_pos_counter.sv
// Row/column position of the read pointer; column wraps into the row, row wraps to zero.
module img_pos_counter
    import memory_controller_pkg::*;
#(
    parameter int unsigned MAX_ROW = memory_controller_pkg::MAX_ROW,
    parameter int unsigned MAX_COL = memory_controller_pkg::MAX_COL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col
);

    localparam logic [POS_W-1:0] LAST_ROW = POS_W'(MAX_ROW - 1);
    localparam logic [POS_W-1:0] LAST_COL = POS_W'(MAX_COL - 1);

    logic [POS_W-1:0] row_r;
    logic [POS_W-1:0] col_r;

    // Position register: cleared on reset/clear, advanced once per BRAM read.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row_r <= {POS_W{1'b0}};
            col_r <= {POS_W{1'b0}};
        end else if (inc) begin
            if (col_r == LAST_COL) begin
                col_r <= {POS_W{1'b0}};
                row_r <= (row_r == LAST_ROW) ? {POS_W{1'b0}} : row_r + 10'd1;
            end else begin
                col_r <= col_r + 10'd1;
            end
        end
    end

    assign row = row_r;
    assign col = col_r;

endmodule

// File: rtl/memory_controller.sv
// BRAM read controller: full-frame mode-1 readout and mode-2 burst fetches from a persistent pointer.
// Define MEMCTRL_DEBUG_EN to expose cnt_fetch_o, addr_temp_o and fetch_start_o (tied to 0 otherwise).
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int unsigned MAX_ROW = memory_controller_pkg::MAX_ROW,
    parameter int unsigned MAX_COL = memory_controller_pkg::MAX_COL
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ena_o,
    output logic              wea_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] d2mem_o,
    input  logic [DATA_W-1:0] mem2d_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_en_o,
    input  logic              is_mode1_i,
    input  logic              is_mode2_i,
    input  logic              mode1_run_i,
    output logic              mode1_done_o,
    input  logic              fetch_run_i,
    output logic              fetch_done_o,
    input  logic [LEN_W-1:0]  cnt_len_i,
    output logic [POS_W-1:0]  cnt_img_row_o,
    output logic [POS_W-1:0]  cnt_img_col_o,
    output logic [DATA_W-1:0] pixel_o,
    output logic              pixel_en_o,
    output logic [LEN_W-1:0]  cnt_fetch_o,
    output logic [ADDR_W-1:0] addr_temp_o,
    output logic              fetch_start_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ROW * MAX_COL - 1);

    mc_state_e         state_r;
    mc_state_e         state_nxt_s;
    logic              md1_start_s;
    logic              fch_start_s;
    logic              more_s;
    logic              ena_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;

    logic              ena_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  cnt_fetch_r;
    logic [ADDR_W-1:0] addr_temp_r;
    logic              pixel_en_r;
    logic              data_en_r;
    logic              mode1_done_r;
    logic              fetch_done_r;

    assign md1_start_s = (state_r == IDLE) && mode1_run_i && is_mode1_i;
    assign fch_start_s = (state_r == IDLE) && fetch_run_i && is_mode2_i && !is_mode1_i;
    // Another burst read is due only while under length and not past the frame end.
    assign more_s      = ((cnt_fetch_r + 20'd1) < len_r) && (addr_r != LAST_ADDR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; FETCH lingers one idle-read cycle so done trails the last data strobe.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (md1_start_s) begin
                    state_nxt_s = MD1_READ;
                end else if (fch_start_s) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MD1_READ: begin
                if (addr_r == LAST_ADDR) begin
                    state_nxt_s = MD1_DONE;
                end else begin
                    state_nxt_s = MD1_READ;
                end
            end
            MD1_DONE:   state_nxt_s = IDLE;
            FETCH: begin
                if (!ena_r) begin
                    state_nxt_s = FETCH_DONE;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            FETCH_DONE: state_nxt_s = IDLE;
            default:    state_nxt_s = IDLE;
        endcase
    end

    // Output logic: next BRAM enable and address for the registered read port.
    always_comb begin
        ena_nxt_s  = 1'b0;
        addr_nxt_s = addr_r;
        case (state_r)
            IDLE: begin
                if (md1_start_s) begin
                    ena_nxt_s  = 1'b1;
                    addr_nxt_s = {ADDR_W{1'b0}};
                end else if (fch_start_s) begin
                    ena_nxt_s  = (cnt_len_i != {LEN_W{1'b0}});
                    addr_nxt_s = addr_temp_r;
                end else begin
                    ena_nxt_s  = 1'b0;
                end
            end
            MD1_READ: begin
                if (addr_r != LAST_ADDR) begin
                    ena_nxt_s  = 1'b1;
                    addr_nxt_s = addr_r + 18'd1;
                end else begin
                    ena_nxt_s  = 1'b0;
                end
            end
            FETCH: begin
                if (ena_r && more_s) begin
                    ena_nxt_s  = 1'b1;
                    addr_nxt_s = addr_r + 18'd1;
                end else begin
                    ena_nxt_s  = 1'b0;
                end
            end
            default: ena_nxt_s = 1'b0;
        endcase
    end

    // Datapath registers: read port, strobes, burst counters and the persistent pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_r        <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            cnt_fetch_r  <= {LEN_W{1'b0}};
            addr_temp_r  <= {ADDR_W{1'b0}};
            pixel_en_r   <= 1'b0;
            data_en_r    <= 1'b0;
            mode1_done_r <= 1'b0;
            fetch_done_r <= 1'b0;
        end else begin
            ena_r        <= ena_nxt_s;
            addr_r       <= addr_nxt_s;
            pixel_en_r   <= ena_r && (state_r == MD1_READ);
            data_en_r    <= ena_r && (state_r == FETCH);
            mode1_done_r <= (state_nxt_s == MD1_DONE);
            fetch_done_r <= (state_nxt_s == FETCH_DONE);
            if (fch_start_s) begin
                cnt_fetch_r <= {LEN_W{1'b0}};
                len_r       <= cnt_len_i;
            end else if ((state_r == FETCH) && ena_r) begin
                cnt_fetch_r <= cnt_fetch_r + 20'd1;
            end
            if (md1_start_s) begin
                addr_temp_r <= {ADDR_W{1'b0}};
            end else if ((state_r == FETCH) && ena_r) begin
                addr_temp_r <= next_addr(addr_temp_r, LAST_ADDR);
            end
        end
    end

    img_pos_counter #(
        .MAX_ROW (MAX_ROW),
        .MAX_COL (MAX_COL)
    ) u_pos (
        .clk (clk),
        .rst (rst),
        .clr (md1_start_s),
        .inc (ena_r),
        .row (cnt_img_row_o),
        .col (cnt_img_col_o)
    );

    assign ena_o        = ena_r;
    assign wea_o        = 1'b0;
    assign addr_o       = addr_r;
    assign d2mem_o      = {DATA_W{1'b0}};
    // BRAM output is already registered; gate it so idle cycles show zero.
    assign pixel_o      = pixel_en_r ? mem2d_i : {DATA_W{1'b0}};
    assign pixel_en_o   = pixel_en_r;
    assign data_o       = data_en_r ? mem2d_i : {DATA_W{1'b0}};
    assign data_en_o    = data_en_r;
    assign mode1_done_o = mode1_done_r;
    assign fetch_done_o = fetch_done_r;

`ifdef MEMCTRL_DEBUG_EN
    logic fetch_start_r;

    // Burst-start strobe for debug visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_start_r <= 1'b0;
        end else begin
            fetch_start_r <= fch_start_s;
        end
    end

    assign cnt_fetch_o   = cnt_fetch_r;
    assign addr_temp_o   = addr_temp_r;
    assign fetch_start_o = fetch_start_r;
`else
    assign cnt_fetch_o   = {LEN_W{1'b0}};
    assign addr_temp_o   = {ADDR_W{1'b0}};
    assign fetch_start_o = 1'b0;
`endif

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller on a reduced 36x540 frame with a behavioural BRAM.
module tb_memory_controller;
    import memory_controller_pkg::*;

    localparam int unsigned ROWS  = 36;
    localparam int unsigned COLS  = 540;
    localparam int unsigned FRAME = ROWS * COLS;
`ifdef MEMCTRL_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ena_o, wea_o, data_en_o, mode1_done_o, fetch_done_o, pixel_en_o, fetch_start_o;
    logic [ADDR_W-1:0] addr_o, addr_temp_o;
    logic [DATA_W-1:0] d2mem_o, data_o, pixel_o;
    logic [DATA_W-1:0] mem2d_i = 8'd0;
    logic              is_mode1_i = 1'b0, is_mode2_i = 1'b0, mode1_run_i = 1'b0, fetch_run_i = 1'b0;
    logic [LEN_W-1:0]  cnt_len_i = 20'd0;
    logic [LEN_W-1:0]  cnt_fetch_o;
    logic [POS_W-1:0]  cnt_img_row_o, cnt_img_col_o;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_pix_q[$];
    logic [DATA_W-1:0] exp_dat_q[$];
    int unsigned chk_cnt = 0, pass_cnt = 0;
    int unsigned md1_done_cnt = 0, fch_done_cnt = 0;
    int unsigned exp_temp = 0, exp_reads = 0;
    bit          burst_has_data = 1'b0, prev_data_en = 1'b0;

    memory_controller #(.MAX_ROW(ROWS), .MAX_COL(COLS)) dut (
        .clk(clk), .rst(rst), .ena_o(ena_o), .wea_o(wea_o), .addr_o(addr_o), .d2mem_o(d2mem_o),
        .mem2d_i(mem2d_i), .data_o(data_o), .data_en_o(data_en_o), .is_mode1_i(is_mode1_i),
        .is_mode2_i(is_mode2_i), .mode1_run_i(mode1_run_i), .mode1_done_o(mode1_done_o),
        .fetch_run_i(fetch_run_i), .fetch_done_o(fetch_done_o), .cnt_len_i(cnt_len_i),
        .cnt_img_row_o(cnt_img_row_o), .cnt_img_col_o(cnt_img_col_o), .pixel_o(pixel_o),
        .pixel_en_o(pixel_en_o), .cnt_fetch_o(cnt_fetch_o), .addr_temp_o(addr_temp_o),
        .fetch_start_o(fetch_start_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_fn(input logic [17:0] a);
        pix_fn = (a[7:0] + 8'h5a) ^ a[15:8] ^ {6'd0, a[17:16]};
    endfunction

    // BRAM model: one-cycle synchronous read.
    always @(posedge clk) begin
        if (ena_o) mem2d_i <= pix_fn(addr_o);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pos();
        int unsigned r;
        r = exp_reads % FRAME;
        check_val("img_row", 32'(cnt_img_row_o), r / COLS);
        check_val("img_col", 32'(cnt_img_col_o), r % COLS);
    endtask

    // Scoreboard monitor: pops expected address/pixel/data on each DUT strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (ena_o) begin
                check_val("wea_d2mem", {23'd0, wea_o, d2mem_o}, 32'd0);
                if (exp_addr_q.size() == 0) check_val("extra_read", 32'(addr_o), 32'hffff_ffff);
                else check_val("addr", 32'(addr_o), 32'(exp_addr_q.pop_front()));
            end
            if (pixel_en_o) begin
                if (exp_pix_q.size() == 0) check_val("extra_pixel", 32'(pixel_o), 32'hffff_ffff);
                else check_val("pixel", 32'(pixel_o), 32'(exp_pix_q.pop_front()));
            end
            if (data_en_o) begin
                if (exp_dat_q.size() == 0) check_val("extra_data", 32'(data_o), 32'hffff_ffff);
                else check_val("data", 32'(data_o), 32'(exp_dat_q.pop_front()));
            end
            if (mode1_done_o) md1_done_cnt++;
            if (fetch_done_o) begin
                fch_done_cnt++;
                check_val("done_after_data", 32'(prev_data_en), 32'(burst_has_data));
            end
        end
        prev_data_en = data_en_o;
    end

    task automatic do_burst(input int unsigned len);
        int unsigned n, lat, start_done;
        n = (len < FRAME - exp_temp) ? len : FRAME - exp_temp;
        for (int unsigned i = 0; i < n; i++) begin
            exp_addr_q.push_back(18'(exp_temp + i));
            exp_dat_q.push_back(pix_fn(18'(exp_temp + i)));
        end
        burst_has_data = (n != 0);
        start_done = fch_done_cnt;
        cnt_len_i = 20'(len);
        fetch_run_i = 1'b1;
        tick();
        fetch_run_i = 1'b0;
        @(negedge clk);
        check_val("fetch_start", 32'(fetch_start_o), 32'(DBG));
        lat = 1;
        while (fetch_done_o !== 1'b1 && lat < n + 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("fetch_latency", lat, n + 2);
        exp_temp  = (exp_temp + n) % FRAME;
        exp_reads = exp_reads + n;
        repeat (3) tick();
        check_val("fetch_done_cnt", fch_done_cnt - start_done, 32'd1);
        check_val("fetch_q_empty", exp_addr_q.size() + exp_dat_q.size(), 32'd0);
        check_pos();
        check_val("addr_temp", 32'(addr_temp_o), DBG ? exp_temp : 32'd0);
        check_val("cnt_fetch", 32'(cnt_fetch_o), DBG ? n : 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat, start_done;
        is_mode1_i  = 1'b1;
        mode1_run_i = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check_val("rst_ctl", {25'd0, ena_o, wea_o, data_en_o, pixel_en_o, mode1_done_o, fetch_done_o, fetch_start_o}, 32'd0);
        check_val("rst_addr", {14'd0, addr_o}, 32'd0);
        check_val("rst_data", {8'd0, pixel_o, data_o, d2mem_o}, 32'd0);
        check_val("rst_pos", {12'd0, cnt_img_row_o, cnt_img_col_o}, 32'd0);
        check_val("rst_dbg", {12'd0, cnt_fetch_o} | {14'd0, addr_temp_o}, 32'd0);
        tick();
        rst = 1'b0;
        mode1_run_i = 1'b0;
        repeat (5) tick();
        check_val("idle_after_rst", 32'(ena_o), 32'd0);

        // Full-frame mode-1 readout with ignored start requests mid-frame.
        exp_reads = 0;
        exp_temp  = 0;
        for (int unsigned a = 0; a < FRAME; a++) begin
            exp_addr_q.push_back(18'(a));
            exp_pix_q.push_back(pix_fn(18'(a)));
        end
        start_done = fch_done_cnt;
        mode1_run_i = 1'b1;
        tick();
        mode1_run_i = 1'b0;
        @(negedge clk);
        lat = 1;
        while (mode1_done_o !== 1'b1 && lat < FRAME + 40) begin
            if (lat == 100) begin
                is_mode2_i = 1'b1; fetch_run_i = 1'b1; mode1_run_i = 1'b1;
            end else if (lat == 101) begin
                is_mode2_i = 1'b0; fetch_run_i = 1'b0; mode1_run_i = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check_val("md1_latency", lat, FRAME + 1);
        repeat (4) tick();
        check_val("md1_done_cnt", md1_done_cnt, 32'd1);
        check_val("md1_no_fetch", fch_done_cnt - start_done, 32'd0);
        check_val("md1_q_empty", exp_addr_q.size() + exp_pix_q.size(), 32'd0);
        check_pos();

        // Fetch request is refused while mode 1 is also selected.
        is_mode2_i = 1'b1;
        cnt_len_i = 20'd10;
        fetch_run_i = 1'b1;
        tick();
        fetch_run_i = 1'b0;
        repeat (6) tick();
        check_val("mode1_blocks_fetch", fch_done_cnt - start_done, 32'd0);

        is_mode1_i = 1'b0;
        do_burst(1080);
        do_burst(540);
        do_burst(0);
        do_burst(20000);
        do_burst(5);

        // Reset in the middle of a burst discards it.
        for (int unsigned i = 0; i < 100; i++) begin
            exp_addr_q.push_back(18'(exp_temp + i));
            exp_dat_q.push_back(pix_fn(18'(exp_temp + i)));
        end
        burst_has_data = 1'b1;
        cnt_len_i = 20'd100;
        fetch_run_i = 1'b1;
        tick();
        fetch_run_i = 1'b0;
        repeat (30) tick();
        start_done = fch_done_cnt;
        rst = 1'b1;
        repeat (2) tick();
        exp_addr_q.delete();
        exp_dat_q.delete();
        rst = 1'b0;
        exp_temp  = 0;
        exp_reads = 0;
        repeat (50) tick();
        check_val("rst_burst_no_done", fch_done_cnt - start_done, 32'd0);
        check_val("rst_burst_idle", 32'(ena_o), 32'd0);
        check_val("rst_addr_temp", 32'(addr_temp_o), 32'd0);
        check_pos();
        do_burst(3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
